dotp_txn_scheduler: RTL and testbench
=====================================

DOTP_TXN_SCHEDULER -- requirements
Module: dotp_txn_scheduler

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 2, as the number of requesters sharing one AXI master (2..4).
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 32, as the transaction base-address width.
REQ-003 The block SHALL take parameter LEN_WIDTH, default 8, as the burst-count field width.
REQ-004 The block SHALL take parameter TIMEOUT_CYCLES, default 1024, as the maximum WAIT_DONE duration before abort.
REQ-005 Ports: ACLK  in  1  sole clock; all logic on rising edge.
REQ-006 Ports: ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-007 Ports: req_valid  in  NUM_REQ  per-requester job request.
REQ-008 Ports: req_ready  out  NUM_REQ  one-hot, job accepted this cycle.
REQ-009 Ports: req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester base address, packed, requester 0 in LSBs.
REQ-010 Ports: req_len  in  NUM_REQ*LEN_WIDTH  per-requester burst count, packed.
REQ-011 Ports: req_wr  in  NUM_REQ  1 = write job, 0 = read job.
REQ-012 Ports: resp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-013 Ports: resp_err  out  1  error/timeout flag, qualified by any resp_valid bit.
REQ-014 Ports: m_base_addr, m_len, m_wr  out  ADDR_WIDTH, LEN_WIDTH, 1  job registered for the AXI master.
REQ-015 Ports: M_INIT_AXI_TXN  out  1  one-cycle start pulse to the AXI master.
REQ-016 Ports: M_TXN_DONE  in  1  master completion level.
REQ-017 Ports: M_ERROR  in  1  master error level.
REQ-018 Ports: busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM SHALL have states IDLE, LAUNCH, WAIT_DONE, RESP.
REQ-020 In IDLE with any req_valid high, the block SHALL grant round-robin starting at rr_ptr, assert req_ready for exactly that requester, latch its addr/len/wr into m_* and go to LAUNCH in the same edge.
REQ-021 rr_ptr SHALL advance to (granted index + 1) mod NUM_REQ on each grant.
REQ-022 LAUNCH SHALL last one cycle with M_INIT_AXI_TXN = 1, then go to WAIT_DONE.
REQ-023 WAIT_DONE SHALL detect completion only on a rising edge of M_TXN_DONE (registered previous value), so a level left high by the prior job is ignored.
REQ-024 On completion, the block SHALL capture err = M_ERROR sampled in the same cycle and go to RESP.
REQ-025 A timeout counter SHALL clear in LAUNCH, increment each WAIT_DONE cycle, and on reaching TIMEOUT_CYCLES-1 force RESP with err = 1.
REQ-026 RESP SHALL last one cycle: resp_valid[owner] = 1, resp_err = err, then go to IDLE.
REQ-027 Minimum job-to-job spacing SHALL be 4 cycles; a new grant is possible in the cycle after RESP.
REQ-028 req_valid deasserted after grant SHALL NOT affect the job in flight.
REQ-029 m_* SHALL hold stable from grant until the next grant.
REQ-030 Simultaneous M_TXN_DONE rise and timeout terminal count SHALL be treated as completion with err = M_ERROR.

Reset
REQ-031 While ARESETN = 0: state IDLE, rr_ptr 0, counters 0, err 0, done_prev 0, m_* 0, and req_ready, resp_valid, resp_err, M_INIT_AXI_TXN, busy all 0.
REQ-032 Reset asserted mid-job SHALL abandon the job silently, with no resp_valid pulse.

Structure
REQ-033 State enum and the default TIMEOUT_CYCLES constant SHALL live in package dotp_sched_pkg.
REQ-034 Round-robin selection SHALL be a sub-module dotp_rr_arbiter: combinational grant from req_valid and rr_ptr.

Verification
REQ-035 Single read job, req0 addr 0x40000000 len 16; master raises DONE 20 cycles after INIT -> one INIT pulse, resp_valid[0] 21 cycles later, resp_err 0.
REQ-036 req0 and req1 both held high for 3 jobs -> grant order 0,1,0; rr_ptr ends at 1.
REQ-037 DONE held high from the prior job, no new rise -> no completion; timeout after 1024 WAIT_DONE cycles sets resp_err 1.
REQ-038 M_ERROR = 1 coincident with the DONE rise -> resp_err 1 on the owner's resp_valid.
REQ-039 ARESETN dropped in WAIT_DONE -> all outputs 0 asynchronously, no resp_valid, next job starts cleanly from rr_ptr 0.
REQ-040 DONE rise and timeout terminal count in the same cycle -> resp_err equals M_ERROR (0).

Source files
------------

// File: rtl/dotp_sched_pkg.sv
// rtl/dotp_sched_pkg.sv - shared state type, defaults and width helper for the transaction scheduler
package dotp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } sched_state_e;

    localparam int DEFAULT_NUM_REQ        = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int min1_clog2(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dotp_rr_arbiter.sv
// rtl/dotp_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module dotp_rr_arbiter
    import dotp_sched_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int PTR_W   = min1_clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    localparam logic [PTR_W:0] N_W = (PTR_W+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_ofs;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W:0]       w_wrap;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = NUM_REQ'(w_dbl >> i_rr_ptr);

    // Lowest set bit of the rotated vector is the first requester at or after the pointer.
    always_comb begin
        w_ofs = '0;
        o_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ofs = PTR_W'(i);
                o_any = 1'b1;
            end
        end
    end

    assign w_sum  = {1'b0, i_rr_ptr} + {1'b0, w_ofs};
    assign w_wrap = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
    assign o_idx  = w_wrap[PTR_W-1:0];

    // One-hot decode of the selected requester.
    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_any && (o_idx == PTR_W'(i))) begin
                o_grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dotp_txn_scheduler.sv
// rtl/dotp_txn_scheduler.sv - shares one AXI master among several job requesters
module dotp_txn_scheduler
    import dotp_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_REQ-1:0]            req_wr,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_err,
    output logic [ADDR_WIDTH-1:0]         m_base_addr,
    output logic [LEN_WIDTH-1:0]          m_len,
    output logic                          m_wr,
    output logic                          M_INIT_AXI_TXN,
    input  logic                          M_TXN_DONE,
    input  logic                          M_ERROR,
    output logic                          busy
);

    localparam int               PTR_W    = min1_clog2(NUM_REQ);
    localparam int               CNT_W    = min1_clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0]   N_W      = (PTR_W+1)'(NUM_REQ);

    sched_state_e          r_state;
    sched_state_e          w_next_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      r_owner;
    logic [CNT_W-1:0]      r_tmo_cnt;
    logic                  r_err;
    logic                  r_done_prev;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [LEN_WIDTH-1:0]  r_m_len;
    logic                  r_m_wr;

    logic [NUM_REQ-1:0]    w_grant;
    logic [PTR_W-1:0]      w_grant_idx;
    logic                  w_grant_any;
    logic                  w_take;
    logic                  w_done_rise;
    logic                  w_tmo_hit;
    logic [PTR_W:0]        w_ptr_inc;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]  w_sel_len;
    logic                  w_sel_wr;

    dotp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_grant_idx),
        .o_any    (w_grant_any)
    );

    assign w_take      = (r_state == ST_IDLE) && w_grant_any;
    // A level still high from the previous job must not count as completion.
    assign w_done_rise = M_TXN_DONE && !r_done_prev;
    assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
    assign w_ptr_inc   = {1'b0, w_grant_idx} + (PTR_W+1)'(1);

    // Select the granted requester's job fields from the packed buses.
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_sel_wr   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
                w_sel_wr   = req_wr[i];
            end
        end
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs; a completion edge wins over the timeout.
    always_comb begin
        w_next_state   = r_state;
        req_ready      = '0;
        resp_valid     = '0;
        resp_err       = 1'b0;
        M_INIT_AXI_TXN = 1'b0;
        busy           = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (ARESETN) begin
                    req_ready = w_grant;
                end
                if (w_grant_any) begin
                    w_next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                M_INIT_AXI_TXN = 1'b1;
                w_next_state   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_done_rise || w_tmo_hit) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    resp_valid[i] = (r_owner == PTR_W'(i));
                end
                resp_err     = r_err;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Latch the granted job and advance the round-robin pointer past the winner.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_m_addr <= '0;
            r_m_len  <= '0;
            r_m_wr   <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else if (w_take) begin
            r_m_addr <= w_sel_addr;
            r_m_len  <= w_sel_len;
            r_m_wr   <= w_sel_wr;
            r_owner  <= w_grant_idx;
            r_rr_ptr <= (w_ptr_inc == N_W) ? '0 : w_ptr_inc[PTR_W-1:0];
        end
    end

    // Track DONE history, run the wait timeout and capture the job's error status.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_done_prev <= 1'b0;
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_done_prev <= M_TXN_DONE;
            case (r_state)
                ST_LAUNCH: r_tmo_cnt <= '0;
                ST_WAIT_DONE: begin
                    if (w_done_rise) begin
                        r_err <= M_ERROR;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_base_addr = r_m_addr;
    assign m_len       = r_m_len;
    assign m_wr        = r_m_wr;

endmodule

// File: tb/tb_dotp_txn_scheduler.sv
// tb/tb_dotp_txn_scheduler.sv - directed self-checking bench for the transaction scheduler
module tb_dotp_txn_scheduler;

    localparam int          N  = 2;
    localparam int          AW = 32;
    localparam int          LW = 8;
    localparam logic [31:0] A0 = 32'h4000_0000;
    localparam logic [31:0] A1 = 32'h8000_1230;
    localparam logic [7:0]  L0 = 8'd16;
    localparam logic [7:0]  L1 = 8'hA5;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]  req_wr;
    logic [N-1:0]  resp_valid;
    logic          resp_err;
    logic [AW-1:0] m_base_addr;
    logic [LW-1:0] m_len;
    logic          m_wr;
    logic          M_INIT_AXI_TXN;
    logic          M_TXN_DONE = 1'b0;
    logic          M_ERROR = 1'b0;
    logic          busy;

    assign req_addr = {A1, A0};
    assign req_len  = {L1, L0};
    assign req_wr   = 2'b10;

    always #5 ACLK = ~ACLK;

    dotp_txn_scheduler #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_wr         (req_wr),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .m_base_addr    (m_base_addr),
        .m_len          (m_len),
        .m_wr           (m_wr),
        .M_INIT_AXI_TXN (M_INIT_AXI_TXN),
        .M_TXN_DONE     (M_TXN_DONE),
        .M_ERROR        (M_ERROR),
        .busy           (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  v;
        bit          hold;
        int          d;
        bit          merr;
        logic [1:0]  ready;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        wr;
        logic        err;
    } vec_t;

    vec_t tbl[8];

    logic [1:0]  g_ready;
    logic [31:0] g_addr;
    logic [7:0]  g_len;
    logic        g_wr;
    logic [1:0]  g_rv;
    logic        g_err;
    int          g_lat;
    bit          g_stray;
    bit          bad;

    // Runs one job from an IDLE cycle: DONE rises during WAIT_DONE cycle d after LAUNCH (d<0: never).
    task automatic do_job(input logic [1:0] v, input bit hold, input int d, input bit merr,
                          input bit drop_done,
                          output logic [1:0] o_ready, output logic [31:0] o_addr,
                          output logic [7:0] o_len, output logic o_wr,
                          output logic [1:0] o_rv, output logic o_err, output int o_lat,
                          output bit o_stray);
        o_rv    = '0;
        o_err   = 1'b0;
        o_lat   = -1;
        o_stray = 1'b0;
        req_valid = v;
        #1;
        o_ready = req_ready;
        @(negedge ACLK);
        #1;
        if (!hold) req_valid = '0;
        if (M_INIT_AXI_TXN !== 1'b1 || busy !== 1'b1 || req_ready !== '0) o_stray = 1'b1;
        o_addr = m_base_addr;
        o_len  = m_len;
        o_wr   = m_wr;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge ACLK);
            #1;
            if (resp_valid !== '0) begin
                o_rv  = resp_valid;
                o_err = resp_err;
                o_lat = k;
                break;
            end
            if (M_INIT_AXI_TXN !== 1'b0 || req_ready !== '0 || busy !== 1'b1) o_stray = 1'b1;
            if (k == d) begin
                M_TXN_DONE = 1'b1;
                M_ERROR    = merr;
            end
        end
        if (drop_done) begin
            M_TXN_DONE = 1'b0;
            M_ERROR    = 1'b0;
        end
        @(negedge ACLK);
        #1;
        if (resp_valid !== '0 || busy !== 1'b0) o_stray = 1'b1;
    endtask

    task automatic chk_job(input string tag, input logic [1:0] ready, input logic [31:0] addr,
                           input logic [7:0] len, input logic wr, input logic err, input int lat);
        chk({tag, "_ready"}, 64'(g_ready), 64'(ready));
        chk({tag, "_addr"},  64'(g_addr),  64'(addr));
        chk({tag, "_len"},   64'(g_len),   64'(len));
        chk({tag, "_wr"},    64'(g_wr),    64'(wr));
        chk({tag, "_resp"},  64'(g_rv),    64'(ready));
        chk({tag, "_err"},   64'(g_err),   64'(err));
        chk({tag, "_lat"},   64'(g_lat),   64'(lat));
        chk({tag, "_proto"}, 64'(g_stray), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 1'b0, 20, 1'b0, 2'b01, A0, L0, 1'b0, 1'b0};
        tbl[1] = '{2'b10, 1'b0,  3, 1'b0, 2'b10, A1, L1, 1'b1, 1'b0};
        tbl[2] = '{2'b11, 1'b1,  5, 1'b0, 2'b01, A0, L0, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 1'b1,  2, 1'b0, 2'b10, A1, L1, 1'b1, 1'b0};
        tbl[4] = '{2'b11, 1'b1,  1, 1'b0, 2'b01, A0, L0, 1'b0, 1'b0};
        tbl[5] = '{2'b11, 1'b0,  4, 1'b0, 2'b10, A1, L1, 1'b1, 1'b0};
        tbl[6] = '{2'b01, 1'b0,  7, 1'b1, 2'b01, A0, L0, 1'b0, 1'b1};
        tbl[7] = '{2'b10, 1'b0,  1, 1'b0, 2'b10, A1, L1, 1'b1, 1'b0};

        // Reset state with requests pending.
        req_valid = 2'b11;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_busy",  64'(busy),           64'(0));
        chk("rst_ready", 64'(req_ready),      64'(0));
        chk("rst_resp",  64'(resp_valid),     64'(0));
        chk("rst_err",   64'(resp_err),       64'(0));
        chk("rst_init",  64'(M_INIT_AXI_TXN), 64'(0));
        chk("rst_addr",  64'(m_base_addr),    64'(0));
        chk("rst_len",   64'(m_len),          64'(0));
        chk("rst_wr",    64'(m_wr),           64'(0));
        req_valid = '0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;

        for (int i = 0; i < 8; i++) begin
            do_job(tbl[i].v, tbl[i].hold, tbl[i].d, tbl[i].merr, 1'b1,
                   g_ready, g_addr, g_len, g_wr, g_rv, g_err, g_lat, g_stray);
            chk_job($sformatf("vec%0d", i), tbl[i].ready, tbl[i].addr, tbl[i].len,
                    tbl[i].wr, tbl[i].err, tbl[i].d + 1);
        end
        req_valid = '0;

        // DONE left high by the previous job must not complete the next one.
        do_job(2'b01, 1'b0, 3, 1'b0, 1'b0, g_ready, g_addr, g_len, g_wr, g_rv, g_err, g_lat, g_stray);
        chk_job("stuck_pre", 2'b01, A0, L0, 1'b0, 1'b0, 4);
        do_job(2'b10, 1'b0, -1, 1'b0, 1'b1, g_ready, g_addr, g_len, g_wr, g_rv, g_err, g_lat, g_stray);
        chk_job("stuck_tmo", 2'b10, A1, L1, 1'b1, 1'b1, 1025);

        // DONE rise one cycle before, and exactly at, the timeout terminal count.
        do_job(2'b01, 1'b0, 1023, 1'b0, 1'b1, g_ready, g_addr, g_len, g_wr, g_rv, g_err, g_lat, g_stray);
        chk_job("tc_minus1", 2'b01, A0, L0, 1'b0, 1'b0, 1024);
        do_job(2'b10, 1'b0, 1024, 1'b0, 1'b1, g_ready, g_addr, g_len, g_wr, g_rv, g_err, g_lat, g_stray);
        chk_job("tc_tie", 2'b10, A1, L1, 1'b1, 1'b0, 1025);

        // Reset in WAIT_DONE after a req0 grant (pointer now 1).
        req_valid = 2'b01;
        @(negedge ACLK);
        #1;
        req_valid = '0;
        @(negedge ACLK);
        @(negedge ACLK);
        #1;
        chk("mid_busy", 64'(busy), 64'(1));
        #2;
        ARESETN   = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("arst_busy",  64'(busy),           64'(0));
        chk("arst_ready", 64'(req_ready),      64'(0));
        chk("arst_init",  64'(M_INIT_AXI_TXN), 64'(0));
        chk("arst_addr",  64'(m_base_addr),    64'(0));
        chk("arst_len",   64'(m_len),          64'(0));
        chk("arst_wr",    64'(m_wr),           64'(0));
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            #1;
            if (resp_valid !== '0 || resp_err !== 1'b0) bad = 1'b1;
        end
        chk("arst_no_resp", 64'(bad), 64'(0));
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        do_job(2'b11, 1'b0, 6, 1'b0, 1'b1, g_ready, g_addr, g_len, g_wr, g_rv, g_err, g_lat, g_stray);
        chk_job("post_rst", 2'b01, A0, L0, 1'b0, 1'b0, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
